// File: rtl/count_sched_pkg.sv
// Shared types, defaults and round-robin pick for the counter scheduler.
package count_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  // First set bit of req searching upward from last+1, wrapping at nreq (nreq <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last,
                                         input int nreq);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = 3'd0;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = int'(last) + i;
      if (idx >= nreq) begin
        idx = idx - nreq;
      end else begin
        idx = idx;
      end
      if ((i <= nreq) && !found && req[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end else begin
        win   = win;
        found = found;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sync_up_counter.sv
// CW-bit up-counter with synchronous clear taking priority over enable.
module sync_up_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] q
);

  logic [CW-1:0] q_q;

  // Count register: clear wins, otherwise increment when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= q_q + CW'(1);
    end else begin
      q_q <= q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/count_scheduler.sv
// Round-robin owner of a single shared up-counter; runs 0..len for the
// granted requester, then pulses done to it.
module count_scheduler
  import count_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic [CW-1:0]      count,
  output logic               busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_e    state_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic [LW-1:0]   last_q;
  logic [CW-1:0]   len_q;

  logic            any_req_s;
  logic [2:0]      winner_s;
  logic [NREQ-1:0] onehot_s;
  logic [CW-1:0]   len_sel_s;
  logic [CW-1:0]   count_s;
  logic            tc_s;
  logic            clr_s;
  logic            en_s;

  // Arbitration and counter control derived from the registered state.
  always_comb begin
    any_req_s = |req;
    winner_s  = rr_pick(8'(req), 3'(last_q), NREQ);
    onehot_s  = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
    len_sel_s = len[int'(winner_s)*CW +: CW];
    tc_s      = (count_s == len_q);
    if (state_q == ST_RUN) begin
      clr_s = tc_s;
      en_s  = !tc_s;
    end else begin
      clr_s = any_req_s;
      en_s  = 1'b0;
    end
  end

  // Two-state scheduler FSM with registered grant/done/busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      last_q  <= LW'(NREQ - 1);
      len_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= '0;
          if (any_req_s) begin
            grant_q <= onehot_s;
            busy_q  <= 1'b1;
            len_q   <= len_sel_s;
            last_q  <= LW'(winner_s);
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (tc_s) begin
            done_q  <= grant_q;
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  sync_up_counter #(.CW(CW)) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .en    (en_s),
    .q     (count_s)
  );

  assign grant = grant_q;
  assign done  = done_q;
  assign count = count_s;
  assign busy  = busy_q;

endmodule

// File: tb/tb_count_scheduler.sv
// Randomized and directed bench for count_scheduler against a transaction-level model.
module tb_count_scheduler;

  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*CW-1:0] len = '0;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [CW-1:0]      count;
  logic               busy;

  int n_total = 0;
  int n_bad   = 0;

  // Model: owner index (-1 = idle), current count, captured length, last winner, pending done.
  int m_owner, m_cnt, m_len, m_last, m_done;

  count_scheduler #(.NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .grant (grant),
    .done  (done),
    .count (count),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_len = 0; m_last = NREQ - 1; m_done = 0;
  endtask

  // One clock of the scheduling rules, using the inputs present at the edge.
  task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] l);
    if (m_owner < 0) begin
      m_done = 0;
      for (int i = 1; i <= NREQ; i++) begin
        int idx;
        idx = (m_last + i) % NREQ;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx;
          m_len   = int'(l[idx*CW +: CW]);
          m_cnt   = 0;
          m_last  = idx;
        end
      end
    end else if (m_cnt == m_len) begin
      m_done  = 1 << m_owner;
      m_owner = -1;
      m_cnt   = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".grant"}, 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check_eq({tag, ".done"},  32'(done),  32'(m_done));
    check_eq({tag, ".count"}, 32'(count), 32'(m_cnt));
    check_eq({tag, ".busy"},  32'(busy),  (m_owner >= 0) ? 32'd1 : 32'd0);
  endtask

  task automatic tick(input string tag);
    logic [NREQ-1:0]    r;
    logic [NREQ*CW-1:0] l;
    r = req;
    l = len;
    @(posedge clk);
    model_step(r, l);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int seq[$];
    int max_cnt, gcycles, guard;

    model_reset();
    #2;
    compare_all("por");
    do_reset();

    // Single request, len0=3.
    req = 4'b0001; len = 16'h0003;
    tick("single");
    req = 4'b0000;
    repeat (6) tick("single");

    // Simultaneous requests 0 and 2.
    do_reset();
    req = 4'b0101; len = 16'h0201;
    repeat (3) tick("simul");
    req = 4'b0100;
    repeat (6) tick("simul");
    req = 4'b0000;
    tick("simul");

    // Round robin with all len=0: record grant order.
    do_reset();
    req = 4'b1111; len = 16'h0000;
    for (int c = 0; c < 12; c++) begin
      tick("rr");
      for (int k = 0; k < NREQ; k++) if (grant[k]) seq.push_back(k);
    end
    check_eq("rr.len", 32'(seq.size()), 32'd6);
    for (int k = 0; k < 6 && k < seq.size(); k++) check_eq("rr.order", 32'(seq[k]), 32'(k % NREQ));
    req = 4'b0000;
    repeat (2) tick("rr");

    // Maximum length: 16 cycles without wrap.
    do_reset();
    req = 4'b0001; len = 16'h000F;
    max_cnt = 0; gcycles = 0;
    for (int c = 0; c < 20; c++) begin
      tick("max");
      req = 4'b0000;
      if (grant != 4'b0000) begin
        gcycles++;
        if (int'(count) > max_cnt) max_cnt = int'(count);
      end
    end
    check_eq("max.cycles", 32'(gcycles), 32'd16);
    check_eq("max.peak", 32'(max_cnt), 32'd15);

    // Reset mid-run while requester 1 has count=2.
    req = 4'b0010; len = 16'h0090;
    guard = 0;
    do begin
      tick("mid");
      guard++;
    end while (!(grant == 4'b0010 && count == 4'd2) && guard < 20);
    check_eq("mid.reach", (guard < 20) ? 32'd1 : 32'd0, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("mid.async");
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1111; len = 16'h0000;
    tick("mid.after");
    check_eq("mid.first", 32'(grant), 32'd1);
    req = 4'b0000;
    repeat (3) tick("mid.after");

    // Request drop and len change during RUN.
    req = 4'b1000; len = 16'h4000;
    tick("drop");
    req = 4'b0000; len = 16'hFFFF;
    repeat (8) tick("drop");

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      req = NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) len = NREQ*CW'($urandom);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
